// File: rtl/npc_seq.sv
// Multi-cycle instruction sequencer: owns PC and instruction register, runs the
// fetch/exec/mem/writeback handshake sequence and gates regfile writeback and commit.
module npc_seq #(
  parameter int unsigned WIDTH    = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  input  logic             dmem_ready,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] nextpc,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_ebreak,
  input  logic             br_taken,
  input  logic             rd_wen,
  input  logic             inst_32bit,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] exe_result,
  output logic             rf_wen,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             commit,
  output logic [WIDTH-1:0] instret,
  output logic             halted,
  output logic             fault
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {StFetch, StExec, StMem, StWb, StHalt, StFault} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, instret_q, dmem_addr_q, load_q;
  logic [31:0]      inst_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             pc_aligned;
  logic             timeout_hit;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] sext_w;

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign pc_plus4   = pc_q + WIDTH'(4);
  assign sext_w     = WIDTH'($signed(exe_result[31:0]));

  // cnt_q holds the waiting cycles already spent; this cycle would be wait number cnt_q+1.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a ready always beats a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (!pc_aligned)      state_d = StFault;
        else if (imem_ready)  state_d = StExec;
        else if (timeout_hit) state_d = StFault;
      end
      StExec: begin
        if (is_ebreak)                state_d = StHalt;
        else if (is_load || is_store) state_d = StMem;
        else                          state_d = StWb;
      end
      StMem: begin
        if (dmem_ready)       state_d = StWb;
        else if (timeout_hit) state_d = StFault;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == StFetch) || (state_q == StMem))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= WIDTH'(RESET_PC);
      inst_q      <= '0;
      instret_q   <= '0;
      cnt_q       <= '0;
      dmem_addr_q <= '0;
      load_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if ((state_q == StFetch) && pc_aligned && imem_ready) inst_q <= imem_rdata;
      if ((state_q == StExec) && !is_ebreak && (is_load || is_store)) begin
        dmem_addr_q <= exe_result;
      end
      if ((state_q == StMem) && dmem_ready) load_q <= dmem_rdata;
      if (state_q == StWb) begin
        pc_q      <= nextpc;
        instret_q <= instret_q + WIDTH'(1);
      end
    end
  end

  // Outputs: state decodes, forced low while reset is held
  always_comb begin
    imem_req = rst && (state_q == StFetch) && pc_aligned;
    dmem_req = rst && (state_q == StMem);
    dmem_we  = dmem_req && is_store;
    rf_wen   = rst && (state_q == StWb) && rd_wen;
    commit   = rst && ((state_q == StWb) || ((state_q == StExec) && is_ebreak));
    halted   = (state_q == StHalt);
    fault    = (state_q == StFault);

    nextpc = br_taken ? br_target : pc_plus4;
    if (br_taken)                        rf_wdata = pc_plus4;
    else if (is_load)                    rf_wdata = load_q;
    else if (inst_32bit && (WIDTH == 64)) rf_wdata = sext_w;
    else                                 rf_wdata = exe_result;
  end

  assign imem_addr = pc_q;
  assign dmem_addr = dmem_addr_q;
  assign inst      = inst_q;
  assign pc        = pc_q;
  assign instret   = instret_q;

endmodule
